collision_scan_ctrl: RTL and testbench
======================================

# collision_scan_ctrl

Frame-level sequencer for dragon collision checks. It accepts one scan request per video frame and snapshots the player, sword and sheep positions together with the dragon segment table. It then walks the segments one per clock, comparing each active segment against every entity. It presents the accumulated hit flags to game logic with a valid/ack handshake, so the comparator datapath runs as one scheduled scan instead of free-running.

## Interface
Parameters:
- NUM_SEG, 7, number of dragon segments; legal range 1..8.
- POS_W, 8, position width in bits; all-ones value means off-field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- frame_start  in  1  single-cycle scan request, normally issued at frame boundary.
- player_pos  in  POS_W  player position.
- sword_pos  in  POS_W  sword position.
- sword_active  in  1  sword present; when low the sword never collides.
- sheep_pos  in  POS_W  sheep position.
- dragon_seg_pos  in  NUM_SEG*POS_W  packed segment positions; segment i is at [i*POS_W +: POS_W].
- dragon_seg_active  in  NUM_SEG  per-segment active mask.
- result_ack  in  1  consumer accepts the result.
- busy  out  1  high while in SCAN.
- result_valid  out  1  result available; held until acknowledged.
- player_hit / sword_hit / sheep_hit  out  1 each  collision flags of the last completed scan.
- overrun  out  1  sticky; a frame_start was dropped.
- sword_hit_seg  out  3  lowest colliding segment index (only with COLLISION_SEG_INDEX_EN).

## Operation
- States:
  - IDLE: waits for frame_start; frame_start → SCAN.
  - SCAN: one segment per cycle; after the last segment → DONE.
  - DONE: holds result_valid until result_ack; ack → IDLE.
- Snapshot on start acceptance:
  - All position inputs, sword_active and dragon_seg_active are registered.
  - seg_idx ← 0; internal accumulators ← 0.
  - Later input changes do not affect the running scan.
- SCAN, each cycle, for snapshot segment seg_idx:
  - If its active bit is set and its position is not all-ones, compare it for equality with each snapshot entity position.
  - An entity position of all-ones never matches.
  - A sword match additionally requires sword_active.
  - Matches OR into the accumulators.
  - Inactive segments still consume their cycle, so scan length is a fixed NUM_SEG cycles.
- Entering DONE: accumulators are copied to the hit outputs. Hit outputs are stable until the next DONE entry.
- frame_start while in SCAN, or in DONE without result_ack: the request is dropped and overrun is set.
- frame_start and result_ack in the same DONE cycle: the ack completes and the new scan is accepted, going directly to SCAN. overrun is not set.
- overrun clears only when a start is accepted.
- result_ack outside DONE is ignored.

## Timing
- Reset (reset low at a clk edge): state IDLE; busy, result_valid, all hit flags, overrun and sword_hit_seg all 0.
- Reset mid-scan or in DONE aborts without producing a result.
- frame_start sampled high at edge E in IDLE:
  - busy is high after E.
  - Segments are evaluated at edges E+1..E+NUM_SEG.
  - result_valid is high after edge E+NUM_SEG; default latency is 7 cycles.
- result_ack high at edge A while result_valid is high: result_valid is low after A.
- Maximum scan rate: one scan per NUM_SEG+1 cycles with ack asserted on the first DONE cycle.
- seg_idx width is 3 bits; no wrap occurs because SCAN exits at NUM_SEG-1.

## Configuration
- COLLISION_SEG_INDEX_EN defined:
  - sword_hit_seg port exists.
  - It holds the lowest segment index with a qualified sword match, captured on DONE entry.
  - It reads 0 when sword_hit is 0.
- COLLISION_SEG_INDEX_EN undefined: port and its tracking logic are absent; all other behaviour is identical.

## Test plan
- Player=0x23, seg2=0x23 active, all other segments elsewhere, frame_start pulse → result_valid after 7 cycles; player_hit=1, sword_hit=0, sheep_hit=0.
- Sword=0x45, sword_active=0, seg4=0x45 active → sword_hit=0. Repeat with sword_active=1 → sword_hit=1, and sword_hit_seg=4 when the macro is defined.
- Sheep=0x10, seg1=0x10 with active bit 0 → sheep_hit=0. Sheep=0xFF, seg0=0xFF active → sheep_hit=0.
- Second frame_start during SCAN → overrun=1, scan completes unchanged. Next accepted start → overrun=0.
- In DONE, frame_start and result_ack in the same cycle → result_valid low next cycle, busy high, second result after 7 more cycles, overrun=0.
- reset low at cycle 3 of SCAN → all outputs 0 next cycle. Later frame_start runs a clean scan.

Source files
------------

// File: rtl/collision_scan_ctrl.sv
// collision_scan_ctrl: frame-scheduled dragon segment collision scan with valid/ack result.
// Define COLLISION_SEG_INDEX_EN to add sword_hit_seg (lowest segment hit by the sword).
module collision_scan_ctrl #(
    parameter int NUM_SEG = 7,
    parameter int POS_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic [POS_W-1:0]         player_pos,
    input  logic [POS_W-1:0]         sword_pos,
    input  logic                     sword_active,
    input  logic [POS_W-1:0]         sheep_pos,
    input  logic [NUM_SEG*POS_W-1:0] dragon_seg_pos,
    input  logic [NUM_SEG-1:0]       dragon_seg_active,
    input  logic                     result_ack,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     player_hit,
    output logic                     sword_hit,
    output logic                     sheep_hit,
    output logic                     overrun
`ifdef COLLISION_SEG_INDEX_EN
    ,
    output logic [2:0]               sword_hit_seg
`endif
);
    localparam logic [POS_W-1:0] OFF = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nxt;

    logic [POS_W-1:0]         player_q, sword_q, sheep_q, seg;
    logic [NUM_SEG*POS_W-1:0] seg_pos_q;
    logic [NUM_SEG-1:0]       seg_act_q;
    logic                     sword_act_q;
    logic [2:0]               seg_idx;
    logic                     acc_p, acc_s, acc_sh;
    logic                     seg_ok, hit_p, hit_s, hit_sh, last, accept;

    // An off-field segment never matches, so entity all-ones is excluded by equality.
    assign seg    = seg_pos_q[int'(seg_idx)*POS_W +: POS_W];
    assign seg_ok = seg_act_q[seg_idx] && seg != OFF;
    assign hit_p  = seg_ok && player_q == seg;
    assign hit_s  = seg_ok && sword_act_q && sword_q == seg;
    assign hit_sh = seg_ok && sheep_q == seg;
    assign last   = seg_idx == 3'(NUM_SEG - 1);
    assign accept = frame_start && (state == IDLE || (state == DONE && result_ack));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        busy         = state == SCAN;
        result_valid = state == DONE;
        if (accept)                          state_nxt = SCAN;
        else if (state == SCAN && last)      state_nxt = DONE;
        else if (state == DONE && result_ack) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_idx    <= '0;
            acc_p      <= 1'b0;
            acc_s      <= 1'b0;
            acc_sh     <= 1'b0;
            player_hit <= 1'b0;
            sword_hit  <= 1'b0;
            sheep_hit  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                player_q    <= player_pos;
                sword_q     <= sword_pos;
                sheep_q     <= sheep_pos;
                sword_act_q <= sword_active;
                seg_pos_q   <= dragon_seg_pos;
                seg_act_q   <= dragon_seg_active;
                seg_idx     <= '0;
                acc_p       <= 1'b0;
                acc_s       <= 1'b0;
                acc_sh      <= 1'b0;
                overrun     <= 1'b0;
            end else if (frame_start) begin
                overrun <= 1'b1;
            end
            if (state == SCAN) begin
                seg_idx <= seg_idx + 3'd1;
                acc_p   <= acc_p | hit_p;
                acc_s   <= acc_s | hit_s;
                acc_sh  <= acc_sh | hit_sh;
                if (last) begin
                    player_hit <= acc_p | hit_p;
                    sword_hit  <= acc_s | hit_s;
                    sheep_hit  <= acc_sh | hit_sh;
                end
            end
        end
    end

`ifdef COLLISION_SEG_INDEX_EN
    logic [2:0] acc_seg;

    // The first qualified sword match wins; acc_s low means no earlier match.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_seg       <= '0;
            sword_hit_seg <= '0;
        end else begin
            if (accept) acc_seg <= '0;
            if (state == SCAN) begin
                if (hit_s && !acc_s) acc_seg <= seg_idx;
                if (last) sword_hit_seg <= acc_s ? acc_seg : (hit_s ? seg_idx : 3'd0);
            end
        end
    end
`endif
endmodule

// File: tb/tb_collision_scan_ctrl.sv
// tb_collision_scan_ctrl: directed test-plan cases plus randomized traffic against a transaction-level model.
module tb_collision_scan_ctrl;
    localparam int NS = 7;
    localparam int PW = 8;

    logic clk = 0, reset = 0, frame_start = 0, sword_active = 0, result_ack = 0;
    logic [PW-1:0] player_pos = 0, sword_pos = 0, sheep_pos = 0;
    logic [NS*PW-1:0] dragon_seg_pos = 0;
    logic [NS-1:0] dragon_seg_active = 0;
    logic busy, result_valid, player_hit, sword_hit, sheep_hit, overrun;
`ifdef COLLISION_SEG_INDEX_EN
    logic [2:0] sword_hit_seg;
`endif

    int n_cmp = 0, n_bad = 0;

    // Model: scan outcome is computed whole at start acceptance, then released after NS edges.
    int m_left = 0;
    logic m_valid = 0, m_ovr = 0;
    logic [2:0] m_hits = 0, m_pend = 0;
    int m_seg = 0, m_pseg = 0;

    collision_scan_ctrl #(.NUM_SEG(NS), .POS_W(PW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .player_pos(player_pos), .sword_pos(sword_pos), .sword_active(sword_active),
        .sheep_pos(sheep_pos), .dragon_seg_pos(dragon_seg_pos),
        .dragon_seg_active(dragon_seg_active), .result_ack(result_ack),
        .busy(busy), .result_valid(result_valid), .player_hit(player_hit),
        .sword_hit(sword_hit), .sheep_hit(sheep_hit), .overrun(overrun)
`ifdef COLLISION_SEG_INDEX_EN
        , .sword_hit_seg(sword_hit_seg)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compute(output logic [2:0] h, output int s);
        logic [PW-1:0] p;
        h = 0;
        s = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            p = dragon_seg_pos[i*PW +: PW];
            if (dragon_seg_active[i] && p != '1) begin
                if (player_pos == p) h[2] = 1;
                if (sword_active && sword_pos == p) begin
                    h[1] = 1;
                    s = i;
                end
                if (sheep_pos == p) h[0] = 1;
            end
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            m_left = 0; m_valid = 0; m_ovr = 0; m_hits = 0; m_seg = 0;
        end else if (m_left > 0) begin
            if (frame_start) m_ovr = 1;
            m_left--;
            if (m_left == 0) begin
                m_valid = 1; m_hits = m_pend; m_seg = m_pseg;
            end
        end else if (m_valid && !(frame_start && result_ack)) begin
            if (frame_start) m_ovr = 1;
            else if (result_ack) m_valid = 0;
        end else if (frame_start) begin
            compute(m_pend, m_pseg);
            m_left = NS; m_valid = 0; m_ovr = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("busy", busy, m_left > 0);
        check("result_valid", result_valid, m_valid);
        check("hits", {player_hit, sword_hit, sheep_hit}, m_hits);
        check("overrun", overrun, m_ovr);
`ifdef COLLISION_SEG_INDEX_EN
        check("sword_hit_seg", sword_hit_seg, m_seg);
`endif
    endtask

    task automatic scan();
        frame_start = 1; step(); frame_start = 0;
        repeat (NS) step();
    endtask

    task automatic ack();
        result_ack = 1; step(); result_ack = 0;
    endtask

    function automatic logic [PW-1:0] rpos();
        int v = $urandom_range(0, 4);
        return v == 4 ? 8'hFF : PW'(v);
    endfunction

    initial begin
        repeat (2) step();
        check("reset_outs", {busy, result_valid, player_hit, sword_hit, sheep_hit, overrun}, 0);
        reset = 1;
        step();
        for (int i = 0; i < NS; i++) dragon_seg_pos[i*PW +: PW] = 8'h80 + 8'(i);
        dragon_seg_active = '1;
        player_pos = 8'h23; sword_pos = 8'h45; sheep_pos = 8'h10;

        dragon_seg_pos[2*PW +: PW] = 8'h23;
        scan();
        check("tp1_valid", result_valid, 1);
        check("tp1_hits", {player_hit, sword_hit, sheep_hit}, 3'b100);
        ack();

        dragon_seg_pos[2*PW +: PW] = 8'h82;
        dragon_seg_pos[4*PW +: PW] = 8'h45;
        scan();
        check("tp2_sword_off", sword_hit, 0);
        ack();
        sword_active = 1;
        scan();
        check("tp2_sword_on", sword_hit, 1);
`ifdef COLLISION_SEG_INDEX_EN
        check("tp2_seg_idx", sword_hit_seg, 4);
`endif
        ack();

        dragon_seg_pos[1*PW +: PW] = 8'h10;
        dragon_seg_active[1] = 0;
        scan();
        check("tp3_inactive", sheep_hit, 0);
        ack();
        sheep_pos = 8'hFF;
        dragon_seg_pos[0 +: PW] = 8'hFF;
        scan();
        check("tp3_offfield", sheep_hit, 0);
        ack();

        frame_start = 1; step(); frame_start = 0;
        repeat (2) step();
        frame_start = 1; step(); frame_start = 0;
        check("tp4_overrun", overrun, 1);
        repeat (NS - 3) step();
        check("tp4_valid", result_valid, 1);
        check("tp4_hits", {player_hit, sword_hit, sheep_hit}, 3'b010);
        ack();
        frame_start = 1; step(); frame_start = 0;
        check("tp4_overrun_clr", overrun, 0);
        repeat (NS) step();

        frame_start = 1; result_ack = 1; step(); frame_start = 0; result_ack = 0;
        check("tp5_valid_low", result_valid, 0);
        check("tp5_busy", busy, 1);
        check("tp5_overrun", overrun, 0);
        repeat (NS - 1) step();
        check("tp5_not_yet", result_valid, 0);
        step();
        check("tp5_valid", result_valid, 1);
        ack();

        frame_start = 1; step(); frame_start = 0;
        repeat (3) step();
        reset = 0; step();
        check("tp6_abort", {busy, result_valid, player_hit, sword_hit, sheep_hit, overrun}, 0);
        reset = 1; step();
        scan();
        check("tp6_clean", result_valid, 1);
        ack();

        repeat (800) begin
            player_pos = rpos(); sword_pos = rpos(); sheep_pos = rpos();
            for (int i = 0; i < NS; i++) dragon_seg_pos[i*PW +: PW] = rpos();
            dragon_seg_active = NS'($urandom);
            sword_active = 1'($urandom);
            reset = $urandom_range(0, 99) != 0;
            frame_start = $urandom_range(0, 3) == 0;
            result_ack = $urandom_range(0, 2) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
